// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing HI/LO results (MULTU/MULT/DIVU/DIV).
// Define MULDIV_DIV_EN to build the divider datapath; otherwise divide ops complete at once as zero.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] operand_a_in,
    input  logic [31:0] operand_b_in,
    input  logic        flush_in,
    output logic        busy_out,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_by_zero_out
);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
`ifdef MULDIV_DIV_EN
        StDiv,
`endif
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        neg_lo_q, neg_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_res;

`ifdef MULDIV_DIV_EN
    logic        neg_hi_q, neg_hi_d;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo_res, rem_res;
`endif

    assign accept = start_in && !flush_in && (state_q == StIdle || state_q == StDone);

    always_comb begin
        a_neg = op_in[0] && operand_a_in[31];
        b_neg = op_in[0] && operand_b_in[31];
        a_mag = a_neg ? (32'd0 - operand_a_in) : operand_a_in;
        b_mag = b_neg ? (32'd0 - operand_b_in) : operand_b_in;
    end

    // acc holds {partial product, remaining multiplier bits}
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        mul_res  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
    end

`ifdef MULDIV_DIV_EN
    // acc holds {partial remainder, dividend bits being shifted into quotient}
    always_comb begin
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_next  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};
        quo_res   = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_res   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
`ifdef MULDIV_DIV_EN
        neg_hi_d = neg_hi_q;
`endif

        if (flush_in) begin
            state_d = StIdle;
            count_d = 6'd0;
        end else begin
            case (state_q)
                StMul: begin
                    if (count_q == 6'd32) begin
                        hi_d    = mul_res[63:32];
                        lo_d    = mul_res[31:0];
                        dbz_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        acc_d   = mul_next;
                        count_d = count_q + 6'd1;
                    end
                end
`ifdef MULDIV_DIV_EN
                StDiv: begin
                    if (count_q == 6'd32) begin
                        hi_d    = rem_res;
                        lo_d    = quo_res;
                        dbz_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        acc_d   = div_next;
                        count_d = count_q + 6'd1;
                    end
                end
`endif
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (accept) begin
                        count_d  = 6'd0;
                        b_d      = b_mag;
                        acc_d    = {32'd0, a_mag};
                        neg_lo_d = a_neg ^ b_neg;
                        if (!op_in[1]) begin
                            state_d = StMul;
                        end else begin
`ifdef MULDIV_DIV_EN
                            neg_hi_d = a_neg;
                            if (operand_b_in == 32'd0) begin
                                hi_d    = operand_a_in;
                                lo_d    = 32'hFFFF_FFFF;
                                dbz_d   = 1'b1;
                                state_d = StDone;
                            end else begin
                                state_d = StDiv;
                            end
`else
                            hi_d    = 32'd0;
                            lo_d    = 32'd0;
                            dbz_d   = 1'b0;
                            state_d = StDone;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= 6'd0;
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            neg_lo_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    always_comb begin
`ifdef MULDIV_DIV_EN
        busy_out = (state_q == StMul) || (state_q == StDiv);
`else
        busy_out = (state_q == StMul);
`endif
        stall_out       = busy_out || accept;
        done_out        = (state_q == StDone);
        hi_out          = hi_q;
        lo_out          = lo_q;
        div_by_zero_out = dbz_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] operand_a_in;
    logic [31:0] operand_b_in;
    logic        flush_in;
    logic        busy_out;
    logic        stall_out;
    logic        done_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero_out;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start_in        (start_in),
        .op_in           (op_in),
        .operand_a_in    (operand_a_in),
        .operand_b_in    (operand_b_in),
        .flush_in        (flush_in),
        .busy_out        (busy_out),
        .stall_out       (stall_out),
        .done_out        (done_out),
        .hi_out          (hi_out),
        .lo_out          (lo_out),
        .div_by_zero_out (div_by_zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edbz, input int elat, input logic ebusy);
        logic [31:0] ph, pl;
        logic        chg, busy_seen;
        int          cyc;
        ph = hi_out;
        pl = lo_out;
        @(negedge clk);
        start_in = 1'b1; op_in = op; operand_a_in = a; operand_b_in = b;
        #1 check({tag, "_stall"}, stall_out, 1'b1);
        @(negedge clk);
        start_in = 1'b0;
        cyc = 0; chg = 1'b0; busy_seen = busy_out;
        while (!done_out && cyc < 100) begin
            chg |= (hi_out !== ph) || (lo_out !== pl);
            @(negedge clk);
            cyc++;
            busy_seen |= busy_out;
        end
        check({tag, "_lat"}, cyc, elat);
        check({tag, "_hold"}, chg, 1'b0);
        check({tag, "_hi"}, hi_out, eh);
        check({tag, "_lo"}, lo_out, el);
        check({tag, "_dbz"}, div_by_zero_out, edbz);
        check({tag, "_busy"}, busy_seen, ebusy);
        @(negedge clk);
        check({tag, "_pulse"}, done_out, 1'b0);
    endtask

    initial begin
        logic [31:0] ph, pl;
        logic        seen, chg, stall_low;
        int          cyc;

        reset = 1'b0; start_in = 1'b0; op_in = 2'b00;
        operand_a_in = 32'd0; operand_b_in = 32'd0; flush_in = 1'b0;
        #3;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_done", done_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_dbz", div_by_zero_out, 1'b0);
        check("rst_stall", stall_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               1'b0, 33, 1'b1);
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
               1'b0, 33, 1'b1);
        run_op("mult_5xm4", 2'b01, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC,
               1'b0, 33, 1'b1);
        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,
               1'b0, 33, 1'b1);
        run_op("mult_max2", 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001,
               1'b0, 33, 1'b1);
        run_op("multu_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0,
               1'b0, 33, 1'b1);
        run_op("multu_hib", 2'b00, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0, 33, 1'b1);
`ifdef MULDIV_DIV_EN
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               1'b0, 33, 1'b1);
        run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
               1'b0, 33, 1'b1);
        run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
        run_op("divu_d0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
`else
        run_op("div_off", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        run_op("divu_off", 2'b10, 32'd100, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
`endif
        run_op("mult_m1m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 33, 1'b1);

        // Flush at iteration 10 with a coincident start.
        ph = hi_out; pl = lo_out;
        @(negedge clk);
        start_in = 1'b1; op_in = 2'b00; operand_a_in = 32'd5; operand_b_in = 32'd6;
        @(negedge clk);
        start_in = 1'b0;
        repeat (10) @(negedge clk);
        flush_in = 1'b1; start_in = 1'b1; operand_a_in = 32'd2; operand_b_in = 32'd2;
        @(negedge clk);
        flush_in = 1'b0; start_in = 1'b0;
        check("flush_busy", busy_out, 1'b0);
        seen = 1'b0; chg = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= done_out;
            chg  |= (hi_out !== ph) || (lo_out !== pl);
        end
        check("flush_nodone", seen, 1'b0);
        check("flush_hold", chg, 1'b0);

        // Flush and start together in IDLE: start discarded.
        flush_in = 1'b1; start_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0; start_in = 1'b0;
        check("flush_idle_busy", busy_out, 1'b0);
        check("flush_idle_done", done_out, 1'b0);

        // Back-to-back: new start in the DONE cycle of DIVU 9/4.
        @(negedge clk);
        start_in = 1'b1; op_in = 2'b10; operand_a_in = 32'd9; operand_b_in = 32'd4;
        @(negedge clk);
        start_in = 1'b0;
        cyc = 0;
        while (!done_out && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
`ifdef MULDIV_DIV_EN
        check("b2b_div_lat", cyc, 33);
        check("b2b_div_lo", lo_out, 32'd2);
        check("b2b_div_hi", hi_out, 32'd1);
`else
        check("b2b_div_lat", cyc, 0);
        check("b2b_div_lo", lo_out, 32'd0);
        check("b2b_div_hi", hi_out, 32'd0);
`endif
        start_in = 1'b1; op_in = 2'b00; operand_a_in = 32'd3; operand_b_in = 32'd3;
        #1 check("b2b_stall", stall_out, 1'b1);
        @(negedge clk);
        start_in = 1'b0;
        check("b2b_busy", busy_out, 1'b1);
        cyc = 0; stall_low = 1'b0;
        while (!done_out && cyc < 100) begin
            stall_low |= !stall_out;
            start_in = (cyc == 5);
            operand_a_in = 32'd7; operand_b_in = 32'd7;
            @(negedge clk);
            start_in = 1'b0;
            cyc++;
        end
        check("b2b_mul_lat", cyc, 33);
        check("b2b_stall_hi", stall_low, 1'b0);
        check("b2b_mul_lo", lo_out, 32'd9);
        check("b2b_mul_hi", hi_out, 32'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start_in = 1'b1; operand_a_in = 32'd100; operand_b_in = 32'd3;
`ifdef MULDIV_DIV_EN
        op_in = 2'b11;
`else
        op_in = 2'b01;
`endif
        @(negedge clk);
        start_in = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_lo", lo_out, 32'd0);
        check("arst_hi", hi_out, 32'd0);
        check("arst_busy", busy_out, 1'b0);
        check("arst_done", done_out, 1'b0);
        check("arst_dbz", div_by_zero_out, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start_in = 1'b1; op_in = 2'b00; operand_a_in = 32'd3; operand_b_in = 32'd5;
        @(negedge clk);
        start_in = 1'b0;
        check("post_rst_busy", busy_out, 1'b1);
        cyc = 0;
        while (!done_out && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("post_rst_lat", cyc, 33);
        check("post_rst_lo", lo_out, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
